// File: rtl/count_en_gen.sv
// Enable-pulse generator for the pipelined counter: run, burst or single-step pacing.
// Define COUNT_EN_SYNC_EN to pass start/stop/step through 2-flop synchronizers.
module count_en_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [DIV_W-1:0] div,
  input  logic [3:0]       burst_len,
  output logic             en,
  output logic             running,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, BURST, STEP} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] pc_q, pc_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       rem_q, rem_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic             running_q, running_d;
  logic [2:0]       ctrl;
  logic [2:0]       prev_q;
  logic             startEdge, stopEdge, stepEdge;

`ifdef COUNT_EN_SYNC_EN
  logic [2:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= {start, stop, step};
      sync2_q <= sync1_q;
    end
  end

  assign ctrl = sync2_q;
`else
  assign ctrl = {start, stop, step};
`endif

  // Previous-value registers reset low, so a level held through reset counts as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 3'b000;
    else     prev_q <= ctrl;
  end

  assign startEdge = ctrl[2] & ~prev_q[2];
  assign stopEdge  = ctrl[1] & ~prev_q[1];
  assign stepEdge  = ctrl[0] & ~prev_q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      div_q     <= '0;
      rem_q     <= 4'd0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      div_q     <= div_d;
      rem_q     <= rem_d;
      en_q      <= en_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    div_d   = div_q;
    rem_d   = rem_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (stopEdge) begin
          state_d = IDLE;
        end else if (stepEdge) begin
          state_d = STEP;
        end else if (startEdge) begin
          div_d = div;
          pc_d  = '0;
          if (burst_len == 4'd0) begin
            state_d = RUN;
          end else begin
            state_d = BURST;
            rem_d   = burst_len;
          end
        end
      end
      RUN, BURST: begin
        if (stopEdge) begin
          state_d = IDLE;
          pc_d    = '0;
          rem_d   = 4'd0;
        end else if (pc_q == div_q) begin
          en_d = 1'b1;
          pc_d = '0;
          if (state_q == BURST) begin
            rem_d = rem_q - 4'd1;
            if (rem_q == 4'd1) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end else begin
          pc_d = pc_q + DIV_W'(1);
        end
      end
      STEP: begin
        state_d = IDLE;
        en_d    = ~stopEdge;
      end
      default: state_d = IDLE;
    endcase
    // running stays up through the done cycle so it falls one edge after the last pulse.
    running_d = (state_d != IDLE) | done_d;
  end

  assign en      = en_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_count_en_gen.sv
// Directed self-checking bench for count_en_gen; adapts its latency to COUNT_EN_SYNC_EN.
module tb_count_en_gen;

`ifdef COUNT_EN_SYNC_EN
  localparam int EL = 2;
`else
  localparam int EL = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, step;
  logic [7:0] div;
  logic [3:0] burst_len;
  logic       en, running, done;
  int         total = 0;
  int         bad = 0;

  count_en_gen #(.DIV_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
    .div(div), .burst_len(burst_len), .en(en), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; stop = 1'b0; step = 1'b0; div = 8'd3; burst_len = 4'd0;
    tick(); tick(); tick();
    total++;
    if ({en, running, done} !== 3'b000) begin
      bad++; $display("[TB] FAIL reset_outputs got=%b want=000", {en, running, done});
    end
    rst = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < EL; i++) tick();
    total++;
    if (running !== 1'b1 || en !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_start_edge running=%b en=%b want 1/0", running, en);
    end
    for (int j = 1; j <= 12; j++) begin
      tick();
      total++;
      if (en !== (j % 4 == 0) || running !== 1'b1) begin
        bad++; $display("[TB] FAIL reset_run_period j=%0d en=%b running=%b want en=%b", j, en, running, (j % 4 == 0));
      end
    end
    stop = 1'b1; tick(); stop = 1'b0;
    for (int i = 0; i < EL; i++) tick();
    total++;
    if (running !== 1'b0 || en !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_run_stop running=%b en=%b want 0/0", running, en);
    end
  endtask

  task automatic test_burst();
    int cnt;
    cnt = 0;
    div = 8'd0; burst_len = 4'd5;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < EL; i++) tick();
    total++;
    if (running !== 1'b1 || en !== 1'b0) begin
      bad++; $display("[TB] FAIL burst_start running=%b en=%b want 1/0", running, en);
    end
    for (int j = 1; j <= 6; j++) begin
      tick();
      if (en === 1'b1) cnt++;
      total++;
      if (en !== (j <= 5) || done !== (j == 5) || running !== (j <= 5)) begin
        bad++; $display("[TB] FAIL burst_cycle j=%0d en=%b done=%b running=%b want %b/%b/%b",
                        j, en, done, running, (j <= 5), (j == 5), (j <= 5));
      end
    end
    total++;
    if (cnt != 5) begin
      bad++; $display("[TB] FAIL burst_count got=%0d want=5", cnt);
    end
  endtask

  task automatic test_step();
    step = 1'b1; tick(); step = 1'b0;
    for (int i = 0; i < EL; i++) tick();
    total++;
    if (running !== 1'b1 || en !== 1'b0) begin
      bad++; $display("[TB] FAIL step_edge running=%b en=%b want 1/0", running, en);
    end
    tick();
    total++;
    if (en !== 1'b1 || running !== 1'b0) begin
      bad++; $display("[TB] FAIL step_pulse en=%b running=%b want 1/0", en, running);
    end
    tick();
    total++;
    if (en !== 1'b0) begin
      bad++; $display("[TB] FAIL step_single en=%b want 0", en);
    end
    // start and step together: step must win
    div = 8'd0; burst_len = 4'd3;
    start = 1'b1; step = 1'b1; tick(); start = 1'b0; step = 1'b0;
    for (int i = 0; i < EL; i++) tick();
    total++;
    if (running !== 1'b1 || en !== 1'b0) begin
      bad++; $display("[TB] FAIL step_prio_edge running=%b en=%b want 1/0", running, en);
    end
    for (int j = 1; j <= 3; j++) begin
      tick();
      total++;
      if (en !== (j == 1) || running !== 1'b0 || done !== 1'b0) begin
        bad++; $display("[TB] FAIL step_prio j=%0d en=%b running=%b done=%b want %b/0/0", j, en, running, done, (j == 1));
      end
    end
  endtask

  task automatic test_stop_div();
    div = 8'd2; burst_len = 4'd0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < EL; i++) tick();
    for (int j = 1; j <= 14; j++) begin
      tick();
      total++;
      if (en !== (j % 3 == 0 && j < 12) || running !== (j < 12) || done !== 1'b0) begin
        bad++; $display("[TB] FAIL stop_run j=%0d en=%b running=%b done=%b want %b/%b/0",
                        j, en, running, done, (j % 3 == 0 && j < 12), (j < 12));
      end
      if (j == 2) div = 8'd7;
      stop = (j == 11 - EL);
    end
    stop = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < EL; i++) tick();
    for (int j = 1; j <= 9; j++) begin
      tick();
      total++;
      if (en !== (j == 8)) begin
        bad++; $display("[TB] FAIL new_div j=%0d en=%b want=%b", j, en, (j == 8));
      end
    end
    stop = 1'b1; tick(); stop = 1'b0;
    for (int i = 0; i < EL; i++) tick();
    total++;
    if (running !== 1'b0) begin
      bad++; $display("[TB] FAIL new_div_stop running=%b want=0", running);
    end
  endtask

  task automatic test_reset_mid_burst();
    int cnt;
    div = 8'd1; burst_len = 4'd15;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < EL; i++) tick();
    for (int j = 1; j <= 12; j++) tick();
    total++;
    if (en !== 1'b1) begin
      bad++; $display("[TB] FAIL midburst_sixth en=%b want=1", en);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({en, running, done} !== 3'b000) begin
      bad++; $display("[TB] FAIL midburst_async got=%b want=000", {en, running, done});
    end
    #1 rst = 1'b0;
    cnt = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < EL; i++) tick();
    for (int j = 1; j <= 31; j++) begin
      tick();
      if (en === 1'b1) cnt++;
      total++;
      if (en !== (j % 2 == 0 && j <= 30) || done !== (j == 30) || running !== (j <= 30)) begin
        bad++; $display("[TB] FAIL fresh_burst j=%0d en=%b done=%b running=%b", j, en, done, running);
      end
    end
    total++;
    if (cnt != 15) begin
      bad++; $display("[TB] FAIL fresh_burst_count got=%0d want=15", cnt);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_step();
    test_stop_div();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_en_gen.md
# count_en_gen

Enable-pulse generator sitting directly upstream of the 4-bit pipelined counter: drives its `en` input. It turns start/stop/step button-style inputs into a paced stream of single-cycle enable pulses, in one of three modes: continuous run, fixed-length burst, or single step. A programmable prescaler sets the pulse period.

## Interface
- `DIV_W`, default 8: prescaler divisor width.
- `clk  input  1  clock; all state updates on rising edge`
- `rst  input  1  reset, asynchronous, active-high`
- `start  input  1  level; rising edge requests run/burst`
- `stop  input  1  level; rising edge aborts activity`
- `step  input  1  level; rising edge requests one pulse`
- `div  input  DIV_W  pulse period minus one; sampled on start`
- `burst_len  input  4  pulses per burst; 0 = continuous run; sampled on start`
- `en  output  1  single-cycle enable pulse to counter (registered)`
- `running  output  1  high while state is not IDLE (registered)`
- `done  output  1  one-cycle pulse when a burst completes (registered)`

## Operation
- Edge detect: each control input has a previous-value register. A rising edge at clock edge k means input=1 at k and 0 at k−1. Previous-value registers reset to 0, so an input held high through reset release yields an edge at the first clock.
- FSM states:
  - IDLE
  - RUN: continuous.
  - BURST: counts remaining pulses.
  - STEP: one pulse, then IDLE.
- Priority when edges coincide: stop > step > start.
- IDLE:
  - start → RUN if `burst_len`==0, else BURST with `rem`=`burst_len`. On the transition, capture `div` into `div_q` and clear prescaler `pc` to 0.
  - step → STEP.
- RUN/BURST:
  - `pc` increments each clock.
  - When `pc`==`div_q`: set `en`=1 for the next cycle and reload `pc` to 0.
  - In BURST, each emitted pulse decrements `rem`. The pulse that takes `rem` to 0 also sets `done`=1 (same cycle as that `en`) and moves to IDLE.
- STEP: `en`=1 for exactly one cycle, then IDLE. Prescaler not used.
- stop in any non-IDLE state → IDLE at that edge. `en` is 0 from that edge on, `done` is not asserted, and `pc` and `rem` are cleared.
- start or step while not IDLE: ignored. No restart, no prescaler reset.
- `div`/`burst_len` changes while not IDLE: ignored until the next start.
- Width: `pc` and `div_q` are `DIV_W` bits; `pc` never exceeds `div_q`, so no wrap. `rem` is 4 bits; the maximum burst is 15.

## Timing
- Reset (asynchronous): `en`=0, `running`=0, `done`=0, state IDLE, `pc`=0, `rem`=0, `div_q`=0, edge registers 0.
- start edge at clock k:
  - `running`=1 after k.
  - First `en` high in the cycle after edge k+`div_q`+1.
  - Subsequent `en` pulses every `div_q`+1 cycles.
  - `div`=0 → `en` high every cycle from k+1.
- Burst of N pulses: last `en` and `done` after edge k+N·(`div_q`+1); `running`=0 after the following edge.
- step edge at k: `en` high only in the cycle after edge k+1; `running` high after k, low after k+1.
- stop edge at k: `en`=0 and `running`=0 after k, even if a pulse was due at k.
- Reset asserted mid-burst: all outputs 0 immediately (asynchronous); no `done`.
- With `COUNT_EN_SYNC_EN`, all start/stop/step latencies above grow by 2 cycles.

## Configuration
- `COUNT_EN_SYNC_EN` defined:
  - Each of start/stop/step passes through a 2-flop synchronizer (reset to 0) before edge detection.
  - Safe for asynchronous button inputs.
  - All control-to-response latencies grow by 2 cycles.
- Not defined: inputs are assumed synchronous to `clk` and feed edge detection directly.

## Test plan
- Reset with start held high, release → at first clock edge, start edge detected; `running`=1; with `div`=3, `burst_len`=0, `en` pulses every 4 cycles; prior to release all outputs 0.
- `div`=0, `burst_len`=5, start → exactly 5 consecutive `en` cycles; `done` coincides with the 5th; `running` drops one cycle later; a counter fed by `en` reaches 5.
- step pulse from IDLE → exactly one `en` cycle, 2 cycles after the step edge; start+step in the same cycle → STEP wins, single pulse, then IDLE.
- Continuous run `div`=2; stop asserted on the cycle a pulse is due → no `en` that cycle or after; `done` stays 0; change `div` to 7 mid-run → period stays 3 until the next start.
- Burst `burst_len`=15, `div`=1; assert `rst` after 6 pulses → `en`/`running`/`done` 0 immediately; a subsequent start gives a full fresh burst of 15.
- Build with `COUNT_EN_SYNC_EN`: repeat the step scenario → `en` 4 cycles after the step edge; start/stop/step glitching high for one cycle still registers exactly once.
